// File: rtl/div_unit_pkg.sv
// Shared types for the divider function unit: register-read and execute
// bundles, function-unit codes and divide operation encoding.
package div_unit_pkg;

  localparam int PRDA_W = 7;

  // Function-unit groups; the divider owns FU_DIV.
  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_MUL = 3'd1,
    FU_DIV = 3'd2,
    FU_MEM = 3'd3,
    FU_CSR = 3'd4
  } fu_t;

  // Low two funct bits select the operation; funct[2] selects the W form.
  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef struct packed {
    logic [15:0]       opid;
    fu_t               fu;
    logic [2:0]        funct;
    logic [PRDA_W-1:0] prda;
    logic [1:0][63:0]  prs;
  } reg_bundle_t;

  typedef struct packed {
    logic [15:0]       opid;
    logic [PRDA_W-1:0] prda;
    logic [63:0]       result;
    logic              exc;
  } exe_bundle_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/div_unit_engine.sv
// One radix-2 restoring divide engine. Operands are reduced to magnitudes at
// accept, divided one bit per cycle, and the signs are restored on the last
// step. Divide-by-zero and signed overflow skip the iteration entirely.
module div_engine
  import div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  div_op_t           op,
  input  logic              w,
  input  logic [63:0]       a,
  input  logic [63:0]       b,
  input  logic [15:0]       opid_in,
  input  logic [PRDA_W-1:0] prda_in,
  input  logic              claim,
  output logic              idle,
  output logic              done,
  output logic [63:0]       result,
  output logic [15:0]       opid_out,
  output logic [PRDA_W-1:0] prda_out
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state;
  logic [6:0]        cnt;
  logic [63:0]       rem_q;
  logic [63:0]       quo_q;
  logic [63:0]       dvs_q;
  logic              neg_q_q;
  logic              neg_r_q;
  logic              is_rem_q;
  logic              w_q;
  logic              spec_q;
  logic [63:0]       result_q;
  logic [15:0]       opid_q;
  logic [PRDA_W-1:0] prda_q;

  logic        sgn, is_rem, a_neg, b_neg, by_zero, ovf;
  logic [63:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_raw, spec_res, quo_init;

  // Accept-time decode: extend operands, take magnitudes, spot special cases.
  always_comb begin
    sgn      = (op == DIV) || (op == REM);
    is_rem   = (op == REM) || (op == REMU);
    a_ext    = w ? (sgn ? sext32(a[31:0]) : {32'b0, a[31:0]}) : a;
    b_ext    = w ? (sgn ? sext32(b[31:0]) : {32'b0, b[31:0]}) : b;
    a_neg    = sgn & a_ext[63];
    b_neg    = sgn & b_ext[63];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    min_val  = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    by_zero  = (b_ext == 64'd0);
    ovf      = sgn && (a_ext == min_val) && (b_ext == {64{1'b1}});
    spec_raw = by_zero ? (is_rem ? a_ext : {64{1'b1}}) : (is_rem ? 64'd0 : min_val);
    spec_res = w ? sext32(spec_raw[31:0]) : spec_raw;
    quo_init = w ? {a_mag[31:0], 32'b0} : a_mag;
  end

  logic [64:0] rem_sh;
  logic        fits;
  logic [63:0] rem_nx, quo_nx, q_fix, r_fix, fin, fin_w;

  // One restoring step plus the sign fix-up applied on the final step.
  always_comb begin
    rem_sh = {rem_q, quo_q[63]};
    fits   = (rem_sh >= {1'b0, dvs_q});
    rem_nx = fits ? (rem_sh[63:0] - dvs_q) : rem_sh[63:0];
    quo_nx = {quo_q[62:0], fits};
    q_fix  = neg_q_q ? -quo_nx : quo_nx;
    r_fix  = neg_r_q ? -rem_nx : rem_nx;
    fin    = is_rem_q ? r_fix : q_fix;
    fin_w  = w_q ? sext32(fin[31:0]) : fin;
  end

  // Engine FSM: IDLE accepts, CALC iterates, DONE holds until claimed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 7'd0;
      rem_q    <= 64'd0;
      quo_q    <= 64'd0;
      dvs_q    <= 64'd0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      is_rem_q <= 1'b0;
      w_q      <= 1'b0;
      spec_q   <= 1'b0;
      result_q <= 64'd0;
      opid_q   <= 16'd0;
      prda_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            opid_q   <= opid_in;
            prda_q   <= prda_in;
            is_rem_q <= is_rem;
            w_q      <= w;
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            dvs_q    <= b_mag;
            rem_q    <= 64'd0;
            quo_q    <= quo_init;
            state    <= S_CALC;
            if (by_zero || ovf) begin
              spec_q   <= 1'b1;
              result_q <= spec_res;
              cnt      <= 7'd1;
            end else begin
              spec_q <= 1'b0;
              cnt    <= w ? 7'd32 : 7'd64;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt - 7'd1;
          if (!spec_q) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
          end
          if (cnt == 7'd1) begin
            state <= S_DONE;
            if (!spec_q) result_q <= fin_w;
          end
        end
        S_DONE: begin
          if (claim) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign idle     = (state == S_IDLE);
  assign done     = (state == S_DONE);
  assign result   = result_q;
  assign opid_out = opid_q;
  assign prda_out = prda_q;

endmodule

// File: rtl/div_unit.sv
// Divider function unit: steers divide candidates from register read onto
// idle engines, reports the idle count to issue, and presents finished
// results on the response lanes until the execute arbiter claims them.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int iwd   = 4,
  parameter int ewd   = 4,
  parameter int nunit = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  reg_bundle_t [iwd-1:0]    reg_bundle,
  output logic [$clog2(nunit):0]   div_free,
  output exe_bundle_t [ewd-1:0]    fu_resp,
  input  logic [ewd-1:0]           fu_claim
);

  localparam int LW = (iwd > 1) ? $clog2(iwd) : 1;
  localparam int FW = $clog2(nunit) + 1;

  logic [nunit-1:0]  eng_idle;
  logic [nunit-1:0]  eng_done;
  logic [nunit-1:0]  start;
  logic [LW-1:0]     sel [nunit];
  logic [63:0]       eng_result [nunit];
  logic [15:0]       eng_opid [nunit];
  logic [PRDA_W-1:0] eng_prda [nunit];

  // Priority assignment: lowest candidate lane goes to lowest idle engine.
  always_comb begin
    logic [nunit-1:0] taken;
    logic             placed;
    taken  = '0;
    placed = 1'b0;
    start  = '0;
    for (int k = 0; k < nunit; k++) sel[k] = '0;
    for (int i = 0; i < iwd; i++) begin
      placed = 1'b0;
      if (reg_bundle[i].opid[15] && (reg_bundle[i].fu == FU_DIV)) begin
        for (int k = 0; k < nunit; k++) begin
          if (!placed && eng_idle[k] && !taken[k]) begin
            taken[k] = 1'b1;
            start[k] = 1'b1;
            sel[k]   = LW'(i);
            placed   = 1'b1;
          end
        end
      end
    end
  end

  // Count of idle engines, used by issue to throttle divide issue.
  always_comb begin
    div_free = '0;
    for (int k = 0; k < nunit; k++) div_free = div_free + FW'(eng_idle[k]);
  end

  for (genvar k = 0; k < nunit; k++) begin : g_eng
    div_engine u_engine (
      .clk      (clk),
      .rst      (rst),
      .start    (start[k]),
      .op       (div_op_t'(reg_bundle[sel[k]].funct[1:0])),
      .w        (reg_bundle[sel[k]].funct[2]),
      .a        (reg_bundle[sel[k]].prs[0]),
      .b        (reg_bundle[sel[k]].prs[1]),
      .opid_in  (reg_bundle[sel[k]].opid),
      .prda_in  (reg_bundle[sel[k]].prda),
      .claim    (fu_claim[k]),
      .idle     (eng_idle[k]),
      .done     (eng_done[k]),
      .result   (eng_result[k]),
      .opid_out (eng_opid[k]),
      .prda_out (eng_prda[k])
    );
  end

  if (nunit < ewd) begin : g_unused
    logic unused_claim;
    assign unused_claim = ^fu_claim[ewd-1:nunit];
  end

  // Response lanes carry a result only while the engine sits in DONE.
  always_comb begin
    fu_resp = '0;
    for (int k = 0; k < nunit; k++) begin
      if (eng_done[k]) begin
        fu_resp[k].opid   = eng_opid[k];
        fu_resp[k].prda   = eng_prda[k];
        fu_resp[k].result = eng_result[k];
        fu_resp[k].exc    = 1'b0;
      end
    end
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative integer divide/remainder function unit. It accepts register-read bundles tagged for the divider and runs up to `nunit` independent radix-2 engines. It presents each finished result as a response lane to the execute-stage result arbiter, and holds that result until the arbiter claims it. It sits between register read and the execute arbiter, occupying one of the five function-unit response groups.

## Interface
- `iwd`, 4, issue width (number of register-read lanes).
- `ewd`, 4, execute width (response lanes per function unit).
- `nunit`, 2, number of divider engines; must satisfy 1 ≤ nunit ≤ ewd.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `reg_bundle`  in  reg_bundle_t[iwd]  register-read bundles; the lane is valid when `opid[15]`=1.
- `div_free`  out  $clog2(nunit)+1  number of engines in IDLE; the issue stage uses it to limit divider issue.
- `fu_resp`  out  exe_bundle_t[ewd]  result lanes; lane j is valid when `opid[15]`=1.
- `fu_claim`  in  ewd  claim from the arbiter; lane j is consumed when `fu_claim[j]`=1.

## Operation
- Engine k drives `fu_resp[k]`. Lanes nunit..ewd-1 are driven to zero permanently.
- **Candidate lanes:** `reg_bundle[i]` with `opid[15]`=1 and `fu`=FU_DIV.
- **Accept:** candidates are assigned in ascending i to the idle engines in ascending k, one candidate per engine per cycle. Candidates beyond the free count are dropped; it is an issue-stage error to exceed `div_free`.
- **Captured at accept:**
  - `opid`, `prda`, `funct`;
  - dividend = `prs[0]`, divisor = `prs[1]`.
- **funct[1:0] encoding:** 0=DIV, 1=DIVU, 2=REM, 3=REMU.
- **funct[2]=1 (W variant):**
  - operate on bits [31:0], sign- or zero-extended per signedness;
  - the 32-bit result is sign-extended to 64 bits.
- **Signed operations:** operate on magnitudes. Negate the quotient if the operand signs differ. The remainder takes the sign of the dividend.
- **Per-engine state machine:**
  - IDLE: on accept → CALC, with counter = 64 (or 32 for W).
  - CALC: one restoring shift-subtract step per cycle; decrement the counter. When counter = 1 → DONE, and the result is fixed up on that edge.
  - DONE: `fu_resp[k]` is valid. On `fu_claim[k]` → IDLE.
- **Special cases:** these are detected at accept, and the engine goes directly to DONE the next cycle.
  - Divide by zero: quotient = all ones (−1); remainder = dividend (W: the extended low word).
  - Signed overflow (DIV/REM with MIN / −1): quotient = MIN; remainder = 0. MIN is 0x8000_0000_0000_0000, or the sign-extended 0x8000_0000 for W.
- **Response fields:** `opid` and `prda` as captured; `result` = quotient or remainder; `exc` = 0. A divider never raises an exception.
- `fu_resp[k]` is all zero unless the engine is in DONE.
- `div_free` is the count of engines in IDLE, computed combinationally from registered state.

## Timing
- **Reset:**
  - all engines go to IDLE and counters are cleared;
  - all `fu_resp` lanes = 0;
  - `div_free` = nunit.
  - Reset is effective immediately (asynchronous), including mid-CALC; in-flight operations are discarded.
- **Normal 64-bit latency:**
  - accept at edge T;
  - DONE after edge T+64;
  - `fu_resp` is valid in cycle T+64 until claimed.
- **W latency:** valid in cycle T+32.
- **Special-case latency:** valid in cycle T+1.
- **Claim:** a claim in cycle C frees the engine at edge C+1. `div_free` increments in cycle C+1, and a new accept is possible at edge C+1 at the earliest, in the following cycle's bundle. An engine is never claimed and accepted on the same edge.
- `fu_claim[k]` while engine k is not in DONE is ignored.
- A result held in DONE is stable across an unbounded number of unclaimed cycles.
- Simultaneous claim on one engine and accept on another are independent.

## Structure
- In `types`:
  - `FU_DIV` constant;
  - `div_op_t` enum (DIV, DIVU, REM, REMU);
  - the `exe_bundle_t` fields `result` and `exc`, if not already present.
- Sub-module `div_engine`:
  - one engine: FSM, counter, remainder/quotient shift registers, sign fix-up;
  - interface: start/op/a/b/tag in; done/result/tag out; claim in.
- `div_unit` is responsible for:
  - lane-to-engine assignment, which is combinational priority logic;
  - the `div_free` popcount;
  - zero-filling the unused lanes.

## Test plan
- DIVU 100/7, single lane: `fu_resp[0].result` = 14 in cycle T+64; hold it for 5 cycles unclaimed and the result is stable. Claim → lane zero next cycle, `div_free` = 2.
- REM −7/2 (64-bit) → −1; DIV −7/2 → −3; REMW 0x8000_0001 by 2 → 0xFFFF_FFFF_FFFF_FFFF at T+32.
- DIV by 0 → 0xFFFF_FFFF_FFFF_FFFF at T+1; REMU 5/0 → 5. DIV MIN/−1 → MIN, and REM of the same operands → 0.
- Two candidates in lanes 1 and 3, with both engines idle: engine 0 takes lane 1 and engine 1 takes lane 3, and `div_free` = 0 the next cycle. A third candidate while engines are busy is dropped with no state change.
- Assert `rst` at cycle T+20 of a CALC operation: `fu_resp` goes to 0 immediately, and `div_free` = nunit. After release, a new DIVU 9/3 returns 3 at the correct latency.
- Claim pulsed on a lane not in DONE: no effect. Random signed and unsigned operands over 2000 operations are checked against a reference model.
